// File: rtl/change_dispenser_pkg.sv
// Shared constants and state encoding for the change dispenser.
// Optional ack timeout is enabled by defining COIN_ACK_TIMEOUT_EN.
package change_dispenser_pkg;

    localparam int DEF_AMT_W = 4;
    localparam int COIN1_VAL = 1;
    localparam int COIN2_VAL = 2;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SELECT   = 3'd1;
    localparam logic [2:0] ST_WAIT_ACK = 3'd2;
    localparam logic [2:0] ST_GAP      = 3'd3;
    localparam logic [2:0] ST_FINISH   = 3'd4;

    typedef enum logic [2:0] {
        IDLE     = ST_IDLE,
        SELECT   = ST_SELECT,
        WAIT_ACK = ST_WAIT_ACK,
        GAP      = ST_GAP,
        FINISH   = ST_FINISH
    } state_t;

endpackage

// File: rtl/change_req_capture.sv
// Request edge detector and saturating pending-amount accumulator.
// Requests arriving while the dispenser cannot take them are banked here.
module change_req_capture
    import change_dispenser_pkg::*;
#(
    parameter int AMT_W = DEF_AMT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pdt,
    input  logic [2:0]       cng,
    input  logic [2:0]       rtn,
    input  logic             take,
    output logic             req_pulse,
    output logic [AMT_W-1:0] amount,
    output logic [AMT_W-1:0] pending
);

    localparam int AMT_MAX = (1 << AMT_W) - 1;

    logic             req_raw;
    logic             req_q;
    logic [4:0]       raw_sum;
    logic [AMT_W:0]   acc_sum;
    logic [AMT_W-1:0] acc_sat;

    assign req_raw   = (pdt & |cng) | |rtn;
    assign req_pulse = req_raw & ~req_q;
    assign raw_sum   = {2'b00, pdt ? cng : 3'd0} + {2'b00, rtn};
    assign acc_sum   = {1'b0, pending} + {1'b0, amount};
    assign acc_sat   = acc_sum[AMT_W] ? '1 : acc_sum[AMT_W-1:0];

    // Clamp the request amount to the accumulator range.
    always_comb begin
        amount = AMT_W'(raw_sum);
        if (int'(raw_sum) > AMT_MAX) amount = '1;
    end

    // Edge history and banking of requests not taken this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q   <= 1'b0;
            pending <= '0;
        end else begin
            req_q <= req_raw;
            if (take)
                pending <= '0;
            else if (req_pulse)
                pending <= acc_sat;
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Greedy two-hopper coin payout with req/ack ejection handshake.
// Define COIN_ACK_TIMEOUT_EN to enable the sticky ack-timeout fault.
module change_dispenser
    import change_dispenser_pkg::*;
#(
    parameter int AMT_W          = DEF_AMT_W,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pdt,
    input  logic [2:0]       cng,
    input  logic [2:0]       rtn,
    input  logic             hop1_empty,
    input  logic             hop2_empty,
    input  logic             eject_ack,
    output logic             eject1,
    output logic             eject2,
    output logic             busy,
    output logic             done,
    output logic [AMT_W-1:0] owed,
    output logic             fault
);

    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    state_t           state, state_nx;
    logic [AMT_W-1:0] remaining, remaining_nx;
    logic [AMT_W-1:0] owed_nx;
    logic             coin2, coin2_nx;
    logic [GAP_W-1:0] gap_cnt, gap_cnt_nx;

    logic             take;
    logic             req_pulse;
    logic [AMT_W-1:0] amount;
    logic [AMT_W-1:0] pending;
    logic [AMT_W-1:0] req_amt;
    logic [AMT_W:0]   start_sum;
    logic [AMT_W-1:0] start_amt;

`ifdef COIN_ACK_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt, tmo_cnt_nx;
    logic             fault_nx;
`else
    localparam int unused_tmo = TIMEOUT_CYCLES;
    assign fault = 1'b0;
`endif

    change_req_capture #(.AMT_W(AMT_W)) u_req (
        .clk       (clk),
        .rst       (rst),
        .pdt       (pdt),
        .cng       (cng),
        .rtn       (rtn),
        .take      (take),
        .req_pulse (req_pulse),
        .amount    (amount),
        .pending   (pending)
    );

    assign take      = (state == IDLE) & ~fault & (req_pulse | |pending);
    assign req_amt   = req_pulse ? amount : '0;
    assign start_sum = {1'b0, req_amt} + {1'b0, pending};
    assign start_amt = start_sum[AMT_W] ? '1 : start_sum[AMT_W-1:0];

    assign eject2 = (state == WAIT_ACK) &  coin2;
    assign eject1 = (state == WAIT_ACK) & ~coin2;
    assign busy   = (state != IDLE);
    assign done   = (state == FINISH);

    // Next-state and datapath updates for the payout sequence.
    always_comb begin
        state_nx     = state;
        remaining_nx = remaining;
        owed_nx      = owed;
        coin2_nx     = coin2;
        gap_cnt_nx   = gap_cnt;
`ifdef COIN_ACK_TIMEOUT_EN
        tmo_cnt_nx   = tmo_cnt;
        fault_nx     = fault;
`endif
        unique case (state)
            IDLE: begin
                if (take) begin
                    remaining_nx = start_amt;
                    owed_nx      = '0;
                    state_nx     = SELECT;
                end
            end
            SELECT: begin
`ifdef COIN_ACK_TIMEOUT_EN
                tmo_cnt_nx = '0;
`endif
                if (remaining >= AMT_W'(COIN2_VAL) && !hop2_empty) begin
                    coin2_nx = 1'b1;
                    state_nx = WAIT_ACK;
                end else if (remaining >= AMT_W'(COIN1_VAL) && !hop1_empty) begin
                    coin2_nx = 1'b0;
                    state_nx = WAIT_ACK;
                end else begin
                    owed_nx  = remaining;
                    state_nx = FINISH;
                end
            end
            WAIT_ACK: begin
                if (eject_ack) begin
                    remaining_nx = remaining - (coin2 ? AMT_W'(COIN2_VAL)
                                                      : AMT_W'(COIN1_VAL));
                    gap_cnt_nx   = '0;
                    state_nx     = GAP;
`ifdef COIN_ACK_TIMEOUT_EN
                end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    fault_nx = 1'b1;
                    owed_nx  = remaining;
                    state_nx = FINISH;
                end else begin
                    tmo_cnt_nx = tmo_cnt + TMO_W'(1);
`endif
                end
            end
            GAP: begin
                if (gap_cnt == GAP_W'(GAP_CYCLES - 1))
                    state_nx = SELECT;
                else
                    gap_cnt_nx = gap_cnt + GAP_W'(1);
            end
            FINISH: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Payout state and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            owed      <= '0;
            coin2     <= 1'b0;
            gap_cnt   <= '0;
        end else begin
            state     <= state_nx;
            remaining <= remaining_nx;
            owed      <= owed_nx;
            coin2     <= coin2_nx;
            gap_cnt   <= gap_cnt_nx;
        end
    end

`ifdef COIN_ACK_TIMEOUT_EN
    // Ack watchdog counter and sticky fault flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
            fault   <= 1'b0;
        end else begin
            tmo_cnt <= tmo_cnt_nx;
            fault   <= fault_nx;
        end
    end
`endif

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Downstream of the vending controller. Consumes its change value (`cng`, qualified by `pdt`) and its cancel-refund value (`rtn`).
- Drives the two coin hoppers (value-1 and value-2) one coin at a time, using a req/ack handshake with the hopper mechanism.
- Pays greedily: value-2 coins first. Reports completion, busy, and any unpaid shortfall.

Parameters:
- AMT_W, 4, width of internal amount accumulator and `owed` output (saturating)
- GAP_CYCLES, 4, idle clocks enforced between consecutive ejections (min 1)
- TIMEOUT_CYCLES, 64, ack timeout in clocks (used only with COIN_ACK_TIMEOUT_EN)

Ports:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  asynchronous, active-high reset
- pdt  in  1  product-release flag from controller
- cng  in  3  change amount from controller, valid when pdt=1
- rtn  in  3  refund amount from controller, nonzero = refund request
- hop1_empty  in  1  value-1 hopper empty
- hop2_empty  in  1  value-2 hopper empty
- eject_ack  in  1  hopper mechanism accepted the current ejection (single-cycle pulse)
- eject1  out  1  request one value-1 coin; level, held until ack
- eject2  out  1  request one value-2 coin; level, held until ack
- busy  out  1  dispensing in progress
- done  out  1  one-cycle pulse when a payout completes (fully or with shortfall)
- owed  out  AMT_W  unpaid remainder of the last payout; holds until next payout starts
- fault  out  1  sticky ack-timeout flag (only with COIN_ACK_TIMEOUT_EN; otherwise tied 0)

Behaviour:
- Reset: all outputs 0; state IDLE; remaining=0; pending=0; edge-detect registers 0.
- Request detect: req_raw = (pdt & |cng) | |rtn. The controller holds these for several cycles, so only the rising edge of req_raw registers a request.
- Request amount = (pdt ? cng : 0) + rtn, zero-extended to AMT_W.
- Request while busy: amount is added to `pending`, saturating at 2^AMT_W-1. No request is lost.
- State machine:
  - IDLE:
    - request edge (or pending≠0): remaining ← amount + pending (saturating), pending ← 0, owed ← 0, busy ← 1 → SELECT.
    - latency: edge at cycle N → busy=1 at N+1, first eject at N+2.
  - SELECT, in priority order:
    - remaining≥2 & !hop2_empty → eject2=1 → WAIT_ACK.
    - remaining≥1 & !hop1_empty → eject1=1 → WAIT_ACK.
    - remaining=0 → FINISH.
    - otherwise (coins unavailable) → owed ← remaining → FINISH.
  - WAIT_ACK:
    - hold eject line until eject_ack=1.
    - on ack: drop eject, remaining -= coin value → GAP.
    - eject_ack while no eject line is high is ignored.
  - GAP: count GAP_CYCLES clocks → SELECT.
  - FINISH: done=1 for one cycle, busy ← 0 → IDLE. `owed` is held.
- Hopper flags are sampled only in SELECT. Emptiness arising mid-handshake does not abort the current ejection.
- Never assert eject1 and eject2 together.
- Simultaneous request edge and FINISH: the request goes to pending; IDLE picks it up next cycle.
- Asserting rst mid-payout clears everything immediately, including pending. Coins already dispensed are not tracked.

Optional Feature:
- Macro COIN_ACK_TIMEOUT_EN.
- Defined:
  - WAIT_ACK counts clocks.
  - If no ack within TIMEOUT_CYCLES: drop eject, set fault (sticky until rst), owed ← remaining, → FINISH.
  - While fault=1, IDLE ignores requests and accumulates them into pending.
- Undefined: no counter; WAIT_ACK waits indefinitely; fault tied 0.

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE, SELECT, WAIT_ACK, GAP, FINISH)
  - coin values COIN1_VAL=1, COIN2_VAL=2
  - default AMT_W
- One natural sub-module: change_req_capture. It contains the req_raw edge detector and the saturating pending accumulator, and outputs req_pulse and amount.

Test Plan:
- Change payout: pdt=1, cng=3 held 5 cycles, hoppers full, ack 2 cycles after each eject → eject2 once then eject1 once; done pulse; owed=0; eject edges ≥ GAP_CYCLES+1 apart.
- Refund with shortfall: rtn=5, hop2_empty=1, hop1 full → five eject1 handshakes, owed=0. Repeat with hop1 going empty after 2 coins → done, owed=3.
- Request while busy: during a rtn=4 payout, pulse pdt=1/cng=2 → after the first done, a second payout of 2 starts within 2 cycles; total 3 eject2.
- Async reset mid-WAIT_ACK: rst high between clock edges → eject lines, busy, owed drop immediately; pending=0; no done pulse.
- Zero-value: pdt=1, cng=0, rtn=0 → no request, busy stays 0.
- COIN_ACK_TIMEOUT_EN: rtn=2, never ack → after TIMEOUT_CYCLES eject2 drops, fault=1, owed=2, done pulse; a later request causes no eject until rst.
